// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: word-addressed synchronous data memory with a
// configurable read latency, a stall handshake towards the hazard unit,
// and the branch-resolution logic that drives PC source selection.
module mem_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrt_data,
    input  logic              saw_branch,
    input  logic [2:0]        branch_op,
    input  logic [2:0]        flags,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    output logic              pc_src
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              stall_d;
    logic              load_rd;
    logic              wr_en;
    logic              cond;

    logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];

    // Writes are only taken in IDLE so a held mem_we never commits twice.
    assign wr_en = (state_q == IDLE) && mem_we && !rst;

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wrt_data;
        end
    end

    // Read FSM next state, latency counter and stall request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_d   = 1'b0;
        load_rd   = 1'b0;
        rd_data_d = rd_data_q;
        case (state_q)
            IDLE: begin
                if (mem_re) begin
                    stall_d = 1'b1;
                    cnt_d   = LAT_M1;
                    if (RD_LAT == 1) begin
                        state_d = DONE;
                        load_rd = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_d = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_d == '0) begin
                    state_d = DONE;
                    load_rd = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // rd_data is loaded on the edge entering DONE so it is visible
        // during the rd_valid cycle; a same-cycle write (only possible with
        // single-cycle latency) is forwarded so the new data is returned.
        if (load_rd) begin
            rd_data_d = wr_en ? wrt_data : mem_q[addr];
        end
    end

    // State, counter and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Branch condition decode from {Z,V,N}.
    always_comb begin
        cond = 1'b0;
        case (branch_op)
            3'b000: cond = !flags[2];
            3'b001: cond = flags[2];
            3'b010: cond = !flags[2] && !flags[0];
            3'b011: cond = flags[0];
            3'b100: cond = !flags[0];
            3'b101: cond = flags[0] || flags[2];
            3'b110: cond = flags[1];
            3'b111: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign stall    = stall_d && !rst;
    assign rd_valid = (state_q == DONE) && !rst;
    assign rd_data  = rd_data_q;
    assign pc_src   = saw_branch && cond && !stall && !rst;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: three instances with read latencies 1, 2 and 3,
// directed cases followed by randomized transactions against a
// transaction-level model of memory contents and per-cycle handshake.
module tb_mem_stage_pipe;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        re  [N];
    logic        we  [N];
    logic [15:0] ad  [N];
    logic [15:0] wd  [N];
    logic        sb;
    logic [2:0]  op;
    logic [2:0]  fl;
    logic [15:0] rdd [N];
    logic        rdv [N];
    logic        stl [N];
    logic        pcs [N];

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl [int];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_stage_pipe #(
            .DATA_W(16),
            .ADDR_W(16),
            .RD_LAT(g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mem_re    (re[g]),
            .mem_we    (we[g]),
            .addr      (ad[g]),
            .wrt_data  (wd[g]),
            .saw_branch(sb),
            .branch_op (op),
            .flags     (fl),
            .rd_data   (rdd[g]),
            .rd_valid  (rdv[g]),
            .stall     (stl[g]),
            .pc_src    (pcs[g])
        );
    end

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch truth table straight from the condition list.
    function automatic logic br_take(input logic [2:0] o, input logic [2:0] f);
        logic z, v, n;
        logic t [8];
        z = f[2];
        v = f[1];
        n = f[0];
        t = '{!z, z, !z && !n, n, !n, n || z, v, 1'b1};
        return t[o];
    endfunction

    function automatic int key(input int k, input logic [15:0] a);
        return k * 65536 + int'(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_br();
        sb = 1'($urandom_range(0, 1));
        op = 3'($urandom_range(0, 7));
        fl = 3'($urandom_range(0, 7));
    endtask

    task automatic do_write(input int k, input logic [15:0] a, input logic [15:0] d);
        we[k] = 1'b1;
        ad[k] = a;
        wd[k] = d;
        #3;
        chk("wr_stall", 32'(stl[k]), 32'd0);
        chk("wr_valid", 32'(rdv[k]), 32'd0);
        step();
        we[k] = 1'b0;
        mdl[key(k, a)] = d;
    endtask

    // Read of instance k (latency k+1). Optional simultaneous write, optional
    // change of write data after acceptance, optional per-cycle random branch.
    task automatic do_read(input int k, input logic [15:0] a, input bit wr,
                           input logic [15:0] d, input bit chg, input bit rb);
        int lat;
        logic [15:0] exp_d;
        bit exp_st;
        lat = k + 1;
        re[k] = 1'b1;
        ad[k] = a;
        we[k] = wr;
        wd[k] = d;
        if (wr) mdl[key(k, a)] = d;
        exp_d = mdl[key(k, a)];
        for (int c = 0; c <= lat; c++) begin
            if (rb) rand_br();
            #3;
            exp_st = (c < lat);
            chk("rd_stall", 32'(stl[k]), 32'(exp_st));
            chk("rd_valid", 32'(rdv[k]), 32'(c == lat));
            chk("rd_pcsrc", 32'(pcs[k]), 32'(sb && br_take(op, fl) && !exp_st));
            if (c == lat) chk("rd_data", 32'(rdd[k]), 32'(exp_d));
            step();
            if (chg && c == 0) wd[k] = ~d;
        end
        re[k] = 1'b0;
        we[k] = 1'b0;
        #3;
        chk("rd_after_valid", 32'(rdv[k]), 32'd0);
        chk("rd_after_stall", 32'(stl[k]), 32'd0);
        chk("rd_after_data", 32'(rdd[k]), 32'(exp_d));
        step();
    endtask

    function automatic logic [15:0] pool_addr(input int i);
        return (i < 16) ? 16'(i + 16'h0100) : 16'(16'hFFF0 + (i - 16));
    endfunction

    initial begin
        rst = 1'b1;
        sb  = 1'b1;
        op  = 3'b111;
        fl  = 3'b000;
        for (int k = 0; k < N; k++) begin
            re[k] = 1'b0;
            we[k] = 1'b0;
            ad[k] = '0;
            wd[k] = '0;
        end
        #1;
        for (int k = 0; k < N; k++) begin
            chk("rst_stall", 32'(stl[k]), 32'd0);
            chk("rst_valid", 32'(rdv[k]), 32'd0);
            chk("rst_data", 32'(rdd[k]), 32'd0);
            chk("rst_pcsrc", 32'(pcs[k]), 32'd0);
        end
        step();
        step();
        rst = 1'b0;
        sb  = 1'b0;

        // Single-cycle latency write then read.
        do_write(0, 16'h0010, 16'hBEEF);
        do_read(0, 16'h0010, 1'b0, 16'h0, 1'b0, 1'b0);

        // Three-cycle latency read; mem_re held through DONE.
        do_write(2, 16'h0005, 16'h1234);
        do_read(2, 16'h0005, 1'b0, 16'h0, 1'b0, 1'b0);

        // Two-cycle latency read+write, write data changed while busy.
        do_write(1, 16'h0007, 16'h0000);
        do_read(1, 16'h0007, 1'b1, 16'hA5A5, 1'b1, 1'b0);
        do_read(1, 16'h0007, 1'b0, 16'h0, 1'b0, 1'b0);

        // Branch sweep with no stall.
        sb = 1'b1;
        fl = 3'b100;
        op = 3'b001; #1; chk("br_eq_z", 32'(pcs[0]), 32'd1);
        op = 3'b000; #1; chk("br_ne_z", 32'(pcs[0]), 32'd0);
        op = 3'b101; #1; chk("br_le_z", 32'(pcs[0]), 32'd1);
        fl = 3'b001;
        op = 3'b011; #1; chk("br_lt_n", 32'(pcs[0]), 32'd1);
        op = 3'b100; #1; chk("br_ge_n", 32'(pcs[0]), 32'd0);
        op = 3'b111;
        for (int f = 0; f < 8; f++) begin
            fl = 3'(f);
            #1;
            chk("br_uncond", 32'(pcs[0]), 32'd1);
        end
        sb = 1'b0;
        for (int o = 0; o < 8; o++) begin
            op = 3'(o);
            fl = 3'(o);
            #1;
            chk("br_nobranch", 32'(pcs[0]), 32'd0);
        end
        step();

        // Branch resolved only when the read stall releases.
        sb = 1'b1;
        op = 3'b001;
        fl = 3'b100;
        do_read(1, 16'h0007, 1'b0, 16'h0, 1'b0, 1'b0);
        sb = 1'b0;

        // Reset in cycle 1 of a three-cycle read.
        do_write(2, 16'h0020, 16'h55AA);
        re[2] = 1'b1;
        ad[2] = 16'h0005;
        sb = 1'b1;
        op = 3'b111;
        step();
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", 32'(stl[2]), 32'd0);
        chk("mid_rst_data", 32'(rdd[2]), 32'd0);
        chk("mid_rst_valid", 32'(rdv[2]), 32'd0);
        chk("mid_rst_pcsrc", 32'(pcs[2]), 32'd0);
        step();
        rst = 1'b0;
        re[2] = 1'b0;
        sb = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #3;
            chk("post_rst_valid", 32'(rdv[2]), 32'd0);
            chk("post_rst_stall", 32'(stl[2]), 32'd0);
            step();
        end
        do_read(2, 16'h0020, 1'b0, 16'h0, 1'b0, 1'b0);

        // Fill an address pool (includes the top of the address space).
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 32; i++) begin
                do_write(k, pool_addr(i), 16'($urandom));
            end
        end

        // Randomized transactions.
        for (int t = 0; t < 120; t++) begin
            int k;
            int kind;
            logic [15:0] a;
            k    = int'($urandom_range(0, N - 1));
            kind = int'($urandom_range(0, 3));
            a    = pool_addr(int'($urandom_range(0, 31)));
            case (kind)
                0: do_write(k, a, 16'($urandom));
                1: do_read(k, a, 1'b0, 16'h0, 1'b0, 1'b1);
                2: do_read(k, a, 1'b1, 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
                default: begin
                    rand_br();
                    #3;
                    chk("rnd_br_idle", 32'(pcs[k]), 32'(sb && br_take(op, fl)));
                    chk("rnd_idle_stall", 32'(stl[k]), 32'd0);
                    step();
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised next-generation MEM pipeline stage for the CPU datapath.
- Combines a synchronous data memory with configurable read latency and a stall handshake to the hazard unit.
- Also contains the branch-resolution logic that drives PC source selection.
- Supports data and address widths other than 16 bits, and multi-cycle memories, while keeping single-cycle writes.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 16, address width; memory depth is 2**ADDR_W words, word-addressed.
- RD_LAT, 1, read latency in cycles (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_re  input  1  read request; held stable by the pipeline while stall is high.
- mem_we  input  1  write request.
- addr  input  ADDR_W  word address.
- wrt_data  input  DATA_W  write data.
- saw_branch  input  1  current instruction is a branch.
- branch_op  input  3  branch condition code.
- flags  input  3  {Z,V,N} from the EX stage.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse: rd_data is updated.
- stall  output  1  freeze upstream stages.
- pc_src  output  1  take branch target.

Behaviour:
- Reset (async, rst=1): state=IDLE, lat counter=0, rd_data=0, rd_valid=0, stall=0. Memory contents are not reset. pc_src is evaluated combinationally and is forced to 0 while rst=1.
- FSM states:
  - IDLE: when mem_re=1, accept the read. stall=1 combinationally in this same cycle (cycle 0), counter loads RD_LAT-1, next state=BUSY. If RD_LAT=1, next state=DONE directly.
  - BUSY: stall=1. Counter decrements each cycle. When the counter reaches 0, next state=DONE.
  - DONE: capture mem[addr] into rd_data, rd_valid=1, stall=0. Next state=IDLE unconditionally. mem_re is ignored in DONE because it is the same instruction still present.
- Timing: rd_valid is high exactly in cycle RD_LAT after acceptance. stall is high for cycles 0..RD_LAT-1.
- Writes:
  - Accepted only in IDLE; mem[addr] <= wrt_data at the rising edge ending that cycle.
  - No stall for a write-only access.
  - mem_we is ignored in BUSY and DONE, so a write is never committed twice.
- mem_re=1 and mem_we=1 together in IDLE: the write commits at the acceptance edge, the read proceeds as normal and returns the newly written data.
- rd_data holds its last value until the next DONE. rd_valid is 0 in every other cycle.
- Branch conditions:
  - cond by branch_op: 000 NE=!Z, 001 EQ=Z, 010 GT=!Z&!N, 011 LT=N, 100 GE=!N, 101 LE=N|Z, 110 OVF=V, 111 UNCOND=1.
  - pc_src = saw_branch & cond & !stall, combinational. It asserts at most once per instruction, in the cycle in which the pipeline advances.
- Reset mid-read: stall drops immediately, no rd_valid is issued, the pending read is discarded, and writes already committed are retained.
- Addresses wrap naturally within 2**ADDR_W; no out-of-range case exists.

Test Plan:
- RD_LAT=1, write 0xBEEF to address 0x0010 (one cycle, stall stays 0), then read 0x0010 -> stall=1 for 1 cycle; next cycle rd_valid=1, rd_data=0xBEEF, stall=0.
- RD_LAT=3, read address 5 holding 0x1234 -> stall high for cycles 0-2, rd_valid only in cycle 3 with rd_data=0x1234. Assert rd_valid again with mem_re still high in DONE -> no second rd_valid.
- RD_LAT=2, mem_re=mem_we=1, addr 7, wrt_data 0xA5A5 (old value 0) -> one write commit, rd_data=0xA5A5 at cycle 2. Change wrt_data while in BUSY -> memory still holds 0xA5A5.
- Branch sweep, stall=0, saw_branch=1:
  - flags Z=1,V=0,N=0: op 001 -> pc_src=1; op 000 -> pc_src=0; op 101 -> pc_src=1.
  - flags N=1: op 011 -> pc_src=1; op 100 -> pc_src=0.
  - op 111 -> pc_src=1 for any flags.
  - saw_branch=0 -> pc_src=0 for every op.
- Branch during a read stall (RD_LAT=2, EQ, Z=1) -> pc_src=0 in cycles 0-1, pc_src=1 only in cycle 2.
- Assert rst in cycle 1 of an RD_LAT=3 read -> stall=0 and rd_data=0 immediately, no rd_valid afterwards. A following read of an address written before the reset returns the written value.
